// File: rtl/movi_seq_ctrl_if.sv
// movi_seq_ctrl_if
//   Bus bundle between the sequence controller and its neighbours.
//   Fetch port  : IADDR/IREQ out, IACK/IDATA in (request/acknowledge,
//                 IDATA valid in the IACK cycle).
//   RF port     : RF_WE/RF_WADDR/RF_WDATA out (single-cycle write strobe).
//   Execute port: EX_VALID/EX_INSTR out, EX_READY in (valid/ready).
//   master = controller side, slave = memory / register file / execute side.
interface movi_seq_ctrl_if #(
  parameter int AW  = 16,
  parameter int RAW = 4
);
  logic [AW-1:0]  IADDR;
  logic           IREQ;
  logic           IACK;
  logic [15:0]    IDATA;
  logic           RF_WE;
  logic [RAW-1:0] RF_WADDR;
  logic [15:0]    RF_WDATA;
  logic           EX_VALID;
  logic [15:0]    EX_INSTR;
  logic           EX_READY;

  modport master (
    output IADDR, IREQ, RF_WE, RF_WADDR, RF_WDATA, EX_VALID, EX_INSTR,
    input  IACK, IDATA, EX_READY
  );

  modport slave (
    input  IADDR, IREQ, RF_WE, RF_WADDR, RF_WDATA, EX_VALID, EX_INSTR,
    output IACK, IDATA, EX_READY
  );
endinterface

// File: rtl/movi_seq_ctrl.sv
// movi_seq_ctrl
//   Fetch/decode/sequence controller for a 16-bit instruction stream.
//   Owns the PC. MOVI (opcode byte 0x02) is executed locally as a two-word
//   move-immediate into the register file; 0x0000 halts; every other word
//   is handed to the execute stage.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   START           one-cycle pulse, honoured only in IDLE/HALTED
//   START_ADDR      initial PC, sampled with START
//   bus (master)    fetch, register-file write and execute handoff signals
//   BUSY            high in every state except IDLE/HALTED
//   HALTED          high in HALTED
//   MOVI_CNT        completed MOVI count, wraps 0xFF->0x00
// All bus outputs are decoded from the state register alone, so a reset
// forces them low in the same cycle without waiting for a clock edge.
module movi_seq_ctrl #(
  parameter int AW  = 16,
  parameter int RAW = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [AW-1:0]          START_ADDR,
  movi_seq_ctrl_if.master        bus,
  output logic                   BUSY,
  output logic                   HALTED,
  output logic [7:0]             MOVI_CNT
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_IMM, S_WRITE, S_DISPATCH, S_HALTED
  } state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [15:0]    ir_q, ir_d;
  logic [15:0]    immr_q, immr_d;
  logic [7:0]     cnt_q, cnt_d;

  logic           ireq;
  logic [AW-1:0]  iaddr;
  logic           rf_we;
  logic [RAW-1:0] rf_waddr;
  logic [15:0]    rf_wdata;
  logic           ex_valid;
  logic [15:0]    ex_instr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      immr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      immr_q  <= immr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    immr_d   = immr_q;
    cnt_d    = cnt_q;
    ireq     = 1'b0;
    iaddr    = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    ex_valid = 1'b0;
    ex_instr = '0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (START) begin
          pc_d    = START_ADDR;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ireq  = 1'b1;
        iaddr = pc_q;
        if (bus.IACK) begin
          ir_d    = bus.IDATA;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[7:0] == 8'h02)  state_d = S_IMM;
        else if (ir_q == 16'h0)  state_d = S_HALTED;
        else                     state_d = S_DISPATCH;
      end
      S_IMM: begin
        // Immediate word follows the opcode; PC wrap makes a top-of-memory
        // opcode pull its immediate from address 0.
        ireq  = 1'b1;
        iaddr = pc_q;
        if (bus.IACK) begin
          immr_d  = bus.IDATA;
          pc_d    = pc_q + AW'(1);
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        rf_we    = 1'b1;
        rf_waddr = ir_q[8 +: RAW];
        rf_wdata = immr_q;
        cnt_d    = cnt_q + 8'd1;
        state_d  = S_FETCH;
      end
      S_DISPATCH: begin
        ex_valid = 1'b1;
        ex_instr = ir_q;
        if (bus.EX_READY) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.IREQ     = ireq;
  assign bus.IADDR    = iaddr;
  assign bus.RF_WE    = rf_we;
  assign bus.RF_WADDR = rf_waddr;
  assign bus.RF_WDATA = rf_wdata;
  assign bus.EX_VALID = ex_valid;
  assign bus.EX_INSTR = ex_instr;

  assign BUSY     = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign HALTED   = (state_q == S_HALTED);
  assign MOVI_CNT = cnt_q;

endmodule

// File: tb/tb_movi_seq_ctrl.sv
// tb_movi_seq_ctrl
//   Directed bench for movi_seq_ctrl. A memory responder serves fetches with
//   a programmable wait; expected fetch addresses, register writes and
//   dispatched words are queued when each program is loaded and popped by a
//   monitor as the controller produces them.
module tb_movi_seq_ctrl;
  localparam int AW  = 16;
  localparam int RAW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          busy, halted;
  logic [7:0]    movi_cnt;

  movi_seq_ctrl_if #(.AW(AW), .RAW(RAW)) bus ();

  movi_seq_ctrl #(.AW(AW), .RAW(RAW)) dut (
    .CLK(clk), .RST(rst), .START(start), .START_ADDR(start_addr),
    .bus(bus), .BUSY(busy), .HALTED(halted), .MOVI_CNT(movi_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_unexp  = 0;

  logic [15:0] mem [logic [15:0]];
  int          wait_cycles = 0;
  int          wcnt = 0;
  bit          spur = 1'b0;

  logic [15:0]       exp_fetch [$];
  logic [RAW+15:0]   exp_wr    [$];
  logic [15:0]       exp_ex    [$];
  logic [7:0]        model_cnt = 8'd0;
  bit                cnt_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acknowledges after wait_cycles idle request cycles;
  // with spur set it also raises IACK when no request is pending.
  always @(negedge clk) begin
    if (bus.IREQ) begin
      if (wcnt >= wait_cycles) begin
        bus.IACK  = 1'b1;
        bus.IDATA = mem.exists(bus.IADDR) ? mem[bus.IADDR] : 16'h0000;
        wcnt      = 0;
      end else begin
        bus.IACK = 1'b0;
        wcnt++;
      end
    end else begin
      bus.IACK  = spur;
      bus.IDATA = spur ? 16'hDEAD : 16'h0000;
      wcnt      = 0;
    end
  end

  // Monitor, sampled mid low phase after inputs have settled.
  logic          prev_req = 1'b0, prev_ack = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  always begin
    logic [RAW+15:0] w;
    @(negedge clk);
    #2;
    if (cnt_pending) begin
      chk("movi_cnt", 32'(movi_cnt), 32'(model_cnt));
      cnt_pending = 1'b0;
    end
    if (!rst) begin
      if (bus.IREQ && bus.IACK) begin
        if (exp_fetch.size() == 0) n_unexp++;
        else chk("fetch_addr", 32'(bus.IADDR), 32'(exp_fetch.pop_front()));
      end
      if (prev_req && !prev_ack && bus.IREQ)
        chk("iaddr_stable", 32'(bus.IADDR), 32'(prev_addr));
      if (bus.RF_WE) begin
        if (exp_wr.size() == 0) n_unexp++;
        else begin
          w = exp_wr.pop_front();
          chk("rf_waddr", 32'(bus.RF_WADDR), 32'(w[RAW+15:16]));
          chk("rf_wdata", 32'(bus.RF_WDATA), 32'(w[15:0]));
        end
        model_cnt   = model_cnt + 8'd1;
        cnt_pending = 1'b1;
      end
      if (bus.EX_VALID) begin
        if (exp_ex.size() == 0) n_unexp++;
        else begin
          chk("ex_instr", 32'(bus.EX_INSTR), 32'(exp_ex[0]));
          if (bus.EX_READY) void'(exp_ex.pop_front());
        end
      end
    end
    prev_req  = bus.IREQ;
    prev_ack  = bus.IACK;
    prev_addr = bus.IADDR;
  end

  // Called at a falling edge; START is seen by exactly one rising edge.
  task automatic pulse_start(input logic [AW-1:0] a);
    start      = 1'b1;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halted(input string tag);
    int n = 0;
    while (!halted && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hold;
    logic [7:0] b;

    rst = 1'b1; start = 1'b0; start_addr = '0;
    bus.EX_READY = 1'b0; bus.IACK = 1'b0; bus.IDATA = '0;
    #1;
    chk("rst_ireq",     32'(bus.IREQ),     32'd0);
    chk("rst_iaddr",    32'(bus.IADDR),    32'd0);
    chk("rst_rf_we",    32'(bus.RF_WE),    32'd0);
    chk("rst_ex_valid", 32'(bus.EX_VALID), 32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_halted",   32'(halted),       32'd0);
    chk("rst_movi_cnt", 32'(movi_cnt),     32'd0);

    mem[16'h0010] = 16'h0302; mem[16'h0011] = 16'hBEEF;
    mem[16'h0040] = 16'h1234;
    mem[16'hFFFF] = 16'h0A02; mem[16'h0000] = 16'h5A5A;
    mem[16'h0080] = 16'h0502; mem[16'h0081] = 16'h1111;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      mem[16'(16'h0100 + 2*i)]     = {b, 8'h02};
      mem[16'(16'h0100 + 2*i + 1)] = 16'(i*3 + 1);
    end

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // MOVI at 0x0010, zero wait, then HALT
    exp_fetch.push_back(16'h0010); exp_fetch.push_back(16'h0011); exp_fetch.push_back(16'h0012);
    exp_wr.push_back({4'd3, 16'hBEEF});
    pulse_start(16'h0010);
    n = 1;
    while (!bus.RF_WE && n < 20) begin @(negedge clk); n++; end
    chk("t1_write_latency", 32'(n), 32'd4);
    @(negedge clk);
    chk("t1_rf_we_one_cycle", 32'(bus.RF_WE), 32'd0);
    wait_halted("t1_halted");
    chk("t1_busy_halted", 32'(busy), 32'd0);
    chk("t1_movi_cnt", 32'(movi_cnt), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_no_ireq_halted", 32'(bus.IREQ), 32'd0);
    end

    // Dispatch from HALTED at 0x0040 with three EX_READY stalls
    exp_fetch.push_back(16'h0040); exp_fetch.push_back(16'h0041);
    exp_ex.push_back(16'h1234);
    pulse_start(16'h0040);
    n = 1;
    while (!bus.EX_VALID && n < 20) begin @(negedge clk); n++; end
    chk("t2_dispatch_latency", 32'(n), 32'd3);
    hold = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.EX_VALID) hold++;
      @(negedge clk);
    end
    bus.EX_READY = 1'b1;
    if (bus.EX_VALID) hold++;
    @(negedge clk);
    bus.EX_READY = 1'b0;
    chk("t2_hold_cycles", 32'(hold), 32'd4);
    chk("t2_valid_dropped", 32'(bus.EX_VALID), 32'd0);
    wait_halted("t2_halted");

    // MOVI at top of memory, one wait per fetch; immediate from 0x0000
    wait_cycles = 1;
    exp_fetch.push_back(16'hFFFF); exp_fetch.push_back(16'h0000); exp_fetch.push_back(16'h0001);
    exp_wr.push_back({4'd10, 16'h5A5A});
    pulse_start(16'hFFFF);
    n = 1;
    while (!bus.RF_WE && n < 30) begin @(negedge clk); n++; end
    chk("t3_write_latency", 32'(n), 32'd6);
    wait_halted("t3_halted");
    chk("t3_movi_cnt", 32'(movi_cnt), 32'd2);

    // Reset while the immediate fetch is pending
    wait_cycles = 4;
    exp_fetch.push_back(16'h0080);
    pulse_start(16'h0080);
    n = 0;
    while (!(bus.IREQ && bus.IADDR == 16'h0081) && n < 40) begin @(negedge clk); n++; end
    chk("t4_in_imm", 32'(bus.IREQ && bus.IADDR == 16'h0081), 32'd1);
    rst = 1'b1;
    model_cnt = 8'd0;
    #1;
    chk("t4_rst_ireq",     32'(bus.IREQ),     32'd0);
    chk("t4_rst_iaddr",    32'(bus.IADDR),    32'd0);
    chk("t4_rst_rf_we",    32'(bus.RF_WE),    32'd0);
    chk("t4_rst_ex_valid", 32'(bus.EX_VALID), 32'd0);
    chk("t4_rst_busy",     32'(busy),         32'd0);
    chk("t4_rst_movi_cnt", 32'(movi_cnt),     32'd0);
    @(negedge clk);
    start = 1'b1; start_addr = 16'h0090;
    @(negedge clk);
    chk("t4_start_in_rst_ignored", 32'(busy), 32'd0);
    wait_cycles = 0;
    exp_fetch.push_back(16'h0090);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("t4_start_at_release", 32'(bus.IREQ), 32'd1);
    wait_halted("t4_halted");

    // 256 back-to-back MOVIs with spurious IACK and a START while busy
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      exp_fetch.push_back(16'(16'h0100 + 2*i));
      exp_fetch.push_back(16'(16'h0100 + 2*i + 1));
      exp_wr.push_back({b[3:0], 16'(i*3 + 1)});
    end
    exp_fetch.push_back(16'h0300);
    spur = 1'b1;
    pulse_start(16'h0100);
    repeat (37) @(negedge clk);
    pulse_start(16'h0500);
    wait_halted("t5_halted");
    spur = 1'b0;
    chk("t5_movi_cnt_wrap", 32'(movi_cnt), 32'd0);

    repeat (2) @(negedge clk);
    chk("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
    chk("write_queue_empty", 32'(exp_wr.size()),    32'd0);
    chk("ex_queue_empty",    32'(exp_ex.size()),    32'd0);
    chk("unexpected_events", 32'(n_unexp),          32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
